// File: rtl/ov7670_stream_pkg.sv
// rtl/ov7670_stream_pkg.sv - shared types and helpers for the OV7670 window stream bridge
// Purpose: stream FSM state encoding, tag width and a saturating counter helper.
// Ports: none (package).
package ov7670_stream_pkg;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      STREAM     = 2'd1,
      DROP       = 2'd2
   } streamState_t;

   // Each FIFO entry carries {sof, eol} ahead of the pixel bits.
   localparam int TAG_BITS = 2;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with full/empty/level and extra-MSB pointers
// Purpose: buffers tagged pixels between the camera side and the display side.
// Ports: clk, reset (sync, active-high); i_wrEn/i_wrData write side;
//        i_rdEn/o_rdData read side (head shown ahead); o_empty, o_full, o_level status.
module sync_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_wrEn,
   input  logic [WIDTH-1:0]         i_wrData,
   input  logic                     i_rdEn,
   output logic [WIDTH-1:0]         o_rdData,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_wrPtrVis;
   logic [AW:0]      r_rdPtr;

   // Occupancy and full use the true write pointer so a write is refused
   // as soon as the storage is used up, regardless of a same-cycle read.
   assign o_level  = r_wrPtr - r_rdPtr;
   assign o_full   = (o_level == FULL_LEVEL);
   // The read side sees the write pointer one cycle late, so a freshly
   // written entry becomes the visible head the cycle after it lands.
   assign o_empty  = (r_wrPtrVis == r_rdPtr);
   assign o_rdData = r_mem[r_rdPtr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (i_wrEn && !o_full) begin
         r_mem[r_wrPtr[AW-1:0]] <= i_wrData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr    <= '0;
         r_wrPtrVis <= '0;
         r_rdPtr    <= '0;
      end else begin
         if (i_wrEn && !o_full) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         r_wrPtrVis <= r_wrPtr;
         if (i_rdEn && !o_empty) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ov7670_window_stream.sv
// rtl/ov7670_window_stream.sv - camera window crop/decimate into a tagged show-ahead pixel FIFO
// Purpose: crops (and optionally 2:1 decimates) the camera frame, tags pixels with
//          start-of-frame/end-of-line, drops the rest of a frame on FIFO overflow.
// Ports: clk, reset (sync, active-high); camera vsync/newPixel/pixelData;
//        display pixelOut/pixelValid/pixelReady/startOfFrame/endOfLine;
//        status overflow (sticky per frame), droppedFrames (saturating), fifoLevel.
module ov7670_window_stream
   import ov7670_stream_pkg::*;
#(
   parameter int PIXEL_WIDTH = 16,
   parameter int SRC_WIDTH   = 640,
   parameter int SRC_HEIGHT  = 480,
   parameter int OUT_WIDTH   = 320,
   parameter int OUT_HEIGHT  = 240,
   parameter int X_OFFSET    = 0,
   parameter int Y_OFFSET    = 0,
   parameter int DECIMATE    = 0,
   parameter int FIFO_DEPTH  = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          vsync,
   input  logic                          newPixel,
   input  logic [PIXEL_WIDTH-1:0]        pixelData,
   output logic [PIXEL_WIDTH-1:0]        pixelOut,
   output logic                          pixelValid,
   input  logic                          pixelReady,
   output logic                          startOfFrame,
   output logic                          endOfLine,
   output logic                          overflow,
   output logic [7:0]                    droppedFrames,
   output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);
   localparam int XW    = $clog2(SRC_WIDTH) + 1;
   localparam int YW    = $clog2(SRC_HEIGHT) + 1;
   localparam int OW    = $clog2(OUT_WIDTH) + 1;
   localparam int LW    = $clog2(FIFO_DEPTH) + 1;
   localparam int SCALE = (DECIMATE != 0) ? 2 : 1;
   localparam int WIN_W = OUT_WIDTH * SCALE;
   localparam int WIN_H = OUT_HEIGHT * SCALE;
   localparam logic [XW-1:0] X_LAST     = XW'(SRC_WIDTH - 1);
   localparam logic [YW-1:0] Y_END      = YW'(SRC_HEIGHT);
   localparam logic [OW-1:0] OUT_X_LAST = OW'(OUT_WIDTH - 1);

   typedef struct packed {
      logic                   sof;
      logic                   eol;
      logic [PIXEL_WIDTH-1:0] data;
   } taggedPixel_t;

   streamState_t        r_state;
   streamState_t        w_nextState;
   logic                r_vsyncQ;
   logic [XW-1:0]       r_srcX;
   logic [YW-1:0]       r_srcY;
   logic [OW-1:0]       r_outX;
   logic                r_sofPending;
   logic                r_overflow;
   logic [7:0]          r_droppedFrames;

   logic                w_vsyncFall;
   logic                w_vsyncRise;
   logic signed [31:0]  w_dx;
   logic signed [31:0]  w_dy;
   logic                w_inWindow;
   logic                w_wrEn;
   logic                w_dropHit;
   logic                w_frameStart;
   logic                w_advance;
   logic                w_fifoEmpty;
   logic                w_fifoFull;
   logic                w_rdEn;
   logic [LW-1:0]       w_fifoLevel;
   taggedPixel_t        w_wrPixel;
   taggedPixel_t        w_headPixel;

   assign w_vsyncFall = r_vsyncQ & ~vsync;
   assign w_vsyncRise = ~r_vsyncQ & vsync;

   // Window test in 32-bit signed arithmetic so offsets never wrap.
   assign w_dx = $signed(32'(r_srcX)) - X_OFFSET;
   assign w_dy = $signed(32'(r_srcY)) - Y_OFFSET;
   assign w_inWindow = (w_dx >= 0) && (w_dx < WIN_W) &&
                       (w_dy >= 0) && (w_dy < WIN_H) &&
                       (r_srcY < Y_END) &&
                       ((DECIMATE == 0) || (!w_dx[0] && !w_dy[0]));

   always_comb begin
      w_nextState  = r_state;
      w_wrEn       = 1'b0;
      w_dropHit    = 1'b0;
      w_frameStart = 1'b0;
      w_advance    = 1'b0;
      case (r_state)
         WAIT_FRAME: begin
            if (w_vsyncFall) begin
               w_frameStart = 1'b1;
               w_nextState  = STREAM;
            end
         end
         STREAM: begin
            if (w_vsyncRise) begin
               w_nextState = WAIT_FRAME;
            end else if (newPixel) begin
               w_advance = 1'b1;
               if (w_inWindow) begin
                  if (w_fifoFull) begin
                     w_dropHit   = 1'b1;
                     w_nextState = DROP;
                  end else begin
                     w_wrEn = 1'b1;
                  end
               end
            end
         end
         DROP: begin
            if (w_vsyncRise) begin
               w_nextState = WAIT_FRAME;
            end
         end
         default: w_nextState = WAIT_FRAME;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= WAIT_FRAME;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vsyncQ        <= 1'b0;
         r_srcX          <= '0;
         r_srcY          <= '0;
         r_outX          <= '0;
         r_sofPending    <= 1'b0;
         r_overflow      <= 1'b0;
         r_droppedFrames <= '0;
      end else begin
         r_vsyncQ <= vsync;
         if (w_frameStart) begin
            r_srcX       <= '0;
            r_srcY       <= '0;
            r_outX       <= '0;
            r_sofPending <= 1'b1;
            r_overflow   <= 1'b0;
         end else if (w_advance) begin
            if (r_srcX == X_LAST) begin
               r_srcX <= '0;
               // Parks at SRC_HEIGHT so surplus lines fall outside the window.
               if (r_srcY != Y_END) begin
                  r_srcY <= r_srcY + 1'b1;
               end
            end else begin
               r_srcX <= r_srcX + 1'b1;
            end
         end
         if (w_wrEn) begin
            r_sofPending <= 1'b0;
            r_outX       <= (r_outX == OUT_X_LAST) ? '0 : r_outX + 1'b1;
         end
         if (w_dropHit) begin
            r_overflow      <= 1'b1;
            r_droppedFrames <= sat_inc8(r_droppedFrames);
         end
      end
   end

   assign w_wrPixel.sof  = r_sofPending;
   assign w_wrPixel.eol  = (r_outX == OUT_X_LAST);
   assign w_wrPixel.data = pixelData;

   sync_fifo #(
      .WIDTH (PIXEL_WIDTH + TAG_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .i_wrEn   (w_wrEn),
      .i_wrData (w_wrPixel),
      .i_rdEn   (w_rdEn),
      .o_rdData (w_headPixel),
      .o_empty  (w_fifoEmpty),
      .o_full   (w_fifoFull),
      .o_level  (w_fifoLevel)
   );

   // Outputs are forced to zero while nothing is valid, giving clean
   // reset values without having to clear the storage array.
   assign pixelValid    = ~w_fifoEmpty;
   assign w_rdEn        = pixelValid & pixelReady;
   assign pixelOut      = pixelValid ? w_headPixel.data : '0;
   assign startOfFrame  = pixelValid & w_headPixel.sof;
   assign endOfLine     = pixelValid & w_headPixel.eol;
   assign overflow      = r_overflow;
   assign droppedFrames = r_droppedFrames;
   assign fifoLevel     = w_fifoLevel;

endmodule

// File: tb/tb_ov7670_window_stream.sv
// tb/tb_ov7670_window_stream.sv - scoreboard bench for ov7670_window_stream (crop and decimate instances)
module tb_ov7670_window_stream;
   localparam int SW = 8, SH = 4, DEPTH = 4;
   localparam int A_OW = 4, A_OH = 2, A_XO = 2, A_YO = 1, A_DEC = 0;
   localparam int B_OW = 2, B_OH = 1, B_XO = 0, B_YO = 0, B_DEC = 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic vsync = 1'b0;
   logic newPixel = 1'b0;
   logic [15:0] pixelData = '0;
   logic readyA = 1'b1;
   logic readyB = 1'b1;
   logic [15:0] outA, outB;
   logic validA, validB, sofA, sofB, eolA, eolB, ovA, ovB;
   logic [7:0] dropA, dropB;
   logic [2:0] levA, levB;

   typedef struct packed {
      logic        sof;
      logic        eol;
      logic [15:0] data;
   } exp_t;

   exp_t qA[$];
   exp_t qB[$];
   int checks = 0;
   int errors = 0;
   int expDropA = 0;
   bit expOvA = 1'b0;
   int rmode = 0;
   bit stallA = 1'b0;
   exp_t prevA;

   always #5 clk = ~clk;

   ov7670_window_stream #(
      .PIXEL_WIDTH(16), .SRC_WIDTH(SW), .SRC_HEIGHT(SH), .OUT_WIDTH(A_OW), .OUT_HEIGHT(A_OH),
      .X_OFFSET(A_XO), .Y_OFFSET(A_YO), .DECIMATE(A_DEC), .FIFO_DEPTH(DEPTH)
   ) dut_a (
      .clk(clk), .reset(reset), .vsync(vsync), .newPixel(newPixel), .pixelData(pixelData),
      .pixelOut(outA), .pixelValid(validA), .pixelReady(readyA), .startOfFrame(sofA),
      .endOfLine(eolA), .overflow(ovA), .droppedFrames(dropA), .fifoLevel(levA)
   );

   ov7670_window_stream #(
      .PIXEL_WIDTH(16), .SRC_WIDTH(SW), .SRC_HEIGHT(SH), .OUT_WIDTH(B_OW), .OUT_HEIGHT(B_OH),
      .X_OFFSET(B_XO), .Y_OFFSET(B_YO), .DECIMATE(B_DEC), .FIFO_DEPTH(DEPTH)
   ) dut_b (
      .clk(clk), .reset(reset), .vsync(vsync), .newPixel(newPixel), .pixelData(pixelData),
      .pixelOut(outB), .pixelValid(validB), .pixelReady(readyB), .startOfFrame(sofB),
      .endOfLine(eolB), .overflow(ovB), .droppedFrames(dropB), .fifoLevel(levB)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Raster index of a source pixel inside the output window, or -1 if it is not kept.
   function automatic int win_index(input int x, input int y, input int ow, input int oh,
                                    input int xo, input int yo, input int dec);
      int dx, dy, sc;
      dx = x - xo;
      dy = y - yo;
      sc = dec + 1;
      if (y >= SH || dx < 0 || dy < 0 || dx >= ow * sc || dy >= oh * sc) return -1;
      if (dec != 0 && ((dx % 2) != 0 || (dy % 2) != 0)) return -1;
      return (dy / sc) * ow + dx / sc;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         stallA = 1'b0;
      end else begin
         if (stallA) begin
            check("A stall valid", 32'(validA), 1);
            check("A stall head", 32'({sofA, eolA, outA}), 32'(prevA));
         end
         if (validA && readyA) begin
            if (qA.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL A unexpected pixel: got 0x%0h, none expected", {sofA, eolA, outA});
            end else begin
               e = qA.pop_front();
               check("A pixel", 32'({sofA, eolA, outA}), 32'(e));
            end
         end
         stallA = validA && !readyA;
         prevA  = {sofA, eolA, outA};
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && validB && readyB) begin
         if (qB.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL B unexpected pixel: got 0x%0h, none expected", {sofB, eolB, outB});
         end else begin
            e = qB.pop_front();
            check("B pixel", 32'({sofB, eolB, outB}), 32'(e));
         end
      end
   end

   // Ready modes: 0 always ready, 1 toggle each cycle, 2 random without two idle cycles in a row, 3 stalled.
   task automatic step();
      @(posedge clk);
      #1;
      case (rmode)
         0: readyA = 1'b1;
         1: readyA = ~readyA;
         2: readyA = readyA ? 1'($urandom_range(0, 1)) : 1'b1;
         default: readyA = 1'b0;
      endcase
   endtask

   task automatic run_frame(input int mode, input bit formula, input int abort_at);
      int nA;
      bit droppedA;
      nA = 0;
      droppedA = 1'b0;
      rmode = mode;
      vsync = 1'b1;
      repeat (3) step();
      vsync = 1'b0;
      step();
      expOvA = 1'b0;
      check("A overflow cleared at frame start", 32'(ovA), 0);
      for (int y = 0; y < SH; y++) begin
         for (int x = 0; x < SW; x++) begin
            int p, ia, ib;
            logic [15:0] d;
            exp_t e;
            p = y * SW + x;
            if (p == abort_at) begin
               reset = 1'b1;
               step();
               check("A valid after reset", 32'(validA), 0);
               check("A level after reset", 32'(levA), 0);
               check("A dropped after reset", 32'(dropA), 0);
               check("B valid after reset", 32'(validB), 0);
               reset = 1'b0;
               qA.delete();
               qB.delete();
               expDropA = 0;
               expOvA = 1'b0;
               return;
            end
            if (mode != 0) repeat ($urandom_range(0, 2)) step();
            d  = formula ? 16'(y * 16 + x) : 16'($urandom);
            ia = win_index(x, y, A_OW, A_OH, A_XO, A_YO, A_DEC);
            ib = win_index(x, y, B_OW, B_OH, B_XO, B_YO, B_DEC);
            if (ia >= 0 && !droppedA) begin
               if (mode == 3 && nA == DEPTH) begin
                  droppedA = 1'b1;
                  expOvA = 1'b1;
                  if (expDropA < 255) expDropA++;
               end else begin
                  e.sof = (ia == 0);
                  e.eol = ((ia % A_OW) == A_OW - 1);
                  e.data = d;
                  qA.push_back(e);
               end
               nA++;
            end
            if (ib >= 0) begin
               e.sof = (ib == 0);
               e.eol = ((ib % B_OW) == B_OW - 1);
               e.data = d;
               qB.push_back(e);
            end
            newPixel = 1'b1;
            pixelData = d;
            step();
            newPixel = 1'b0;
         end
      end
      vsync = 1'b1;
      step();
      check("A overflow at frame end", 32'(ovA), 32'(expOvA));
      check("A droppedFrames", 32'(dropA), 32'(expDropA));
      check("B overflow", 32'(ovB), 0);
      check("B droppedFrames", 32'(dropB), 0);
      rmode = 0;
      readyA = 1'b1;
      for (int i = 0; i < 100 && (qA.size() != 0 || qB.size() != 0 || validA || validB); i++) step();
      check("A pixels outstanding after drain", 32'(qA.size()), 0);
      check("B pixels outstanding after drain", 32'(qB.size()), 0);
      check("A level after drain", 32'(levA), 0);
      check("B level after drain", 32'(levB), 0);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (3) step();
      check("reset pixelValid", 32'(validA), 0);
      check("reset pixelOut", 32'(outA), 0);
      check("reset tags", 32'({sofA, eolA}), 0);
      check("reset overflow", 32'(ovA), 0);
      check("reset droppedFrames", 32'(dropA), 0);
      check("reset fifoLevel", 32'(levA), 0);
      check("reset B pixelValid", 32'(validB), 0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 16; i++) begin
         newPixel = 1'b1;
         pixelData = 16'(i);
         step();
         newPixel = 1'b0;
         step();
      end
      repeat (3) step();
      check("pre-vsync A valid", 32'(validA), 0);
      check("pre-vsync A level", 32'(levA), 0);
      check("pre-vsync B level", 32'(levB), 0);

      run_frame(0, 1'b1, -1);
      run_frame(1, 1'b1, -1);
      for (int f = 0; f < 4; f++) run_frame(2, 1'b0, -1);
      run_frame(3, 1'b1, -1);
      run_frame(0, 1'b0, -1);
      run_frame(3, 1'b1, 14);
      run_frame(0, 1'b1, -1);
      for (int f = 0; f < 256; f++) run_frame(3, 1'b0, -1);
      check("droppedFrames saturated", 32'(dropA), 255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ov7670_window_stream.md
# ov7670_window_stream

Parametrised camera-to-display pixel bridge between the OV7670 controller's pixel output (newPixel/pixelData) and the ILI9341 driver's pixel input. It crops a configurable window out of the camera frame, optionally decimates 2:1 in both axes, and buffers pixels in a tagged FIFO with a valid/ready handshake. Each pixel carries start-of-frame and end-of-line tags. The block detects FIFO overflow, drops the rest of that frame, and resynchronises cleanly on the next frame.

## Interface
Parameters:
- PIXEL_WIDTH, 16, pixel bits (RGB565)
- SRC_WIDTH, 640, camera pixels per line
- SRC_HEIGHT, 480, camera lines per frame
- OUT_WIDTH, 320, output pixels per line
- OUT_HEIGHT, 240, output lines per frame
- X_OFFSET, 0, first source column of window
- Y_OFFSET, 0, first source line of window
- DECIMATE, 0, 1 = keep every 2nd column and every 2nd line of the window
- FIFO_DEPTH, 64, entries; power of two, ≥4

Ports:
- Clock/reset: one clock; reset is synchronous and active-high.
  - clk  in  1  system clock
  - reset  in  1  synchronous, active-high
- Camera side (all inputs already in the clk domain):
  - vsync  in  1  high during vertical blank
  - newPixel  in  1  one-cycle strobe, pixelData valid
  - pixelData  in  PIXEL_WIDTH  camera pixel
- Display side:
  - pixelOut  out  PIXEL_WIDTH  FIFO head pixel
  - pixelValid  out  1  FIFO not empty
  - pixelReady  in  1  consumer accepts head
  - startOfFrame  out  1  head is window pixel (0,0)
  - endOfLine  out  1  head is last pixel of an output line
- Status:
  - overflow  out  1  sticky; set on drop, cleared at next frame start
  - droppedFrames  out  8  saturating count of dropped frames
  - fifoLevel  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- States: WAIT_FRAME, STREAM, DROP.
- WAIT_FRAME: ignore newPixel. On vsync falling edge (registered vsync=1, vsync=0): clear srcX, srcY, outX and overflow, then go to STREAM.
- STREAM:
  - Each newPixel advances srcX; at SRC_WIDTH-1 it wraps to 0 and srcY increments.
  - dx = srcX-X_OFFSET, dy = srcY-Y_OFFSET.
  - A pixel is accepted when 0≤dx<OUT_WIDTH·(DECIMATE+1) and 0≤dy<OUT_HEIGHT·(DECIMATE+1). With DECIMATE=1, dx[0] and dy[0] must also be 0.
  - Tags: sof = (first accepted pixel of frame); eol = (outX==OUT_WIDTH-1). outX wraps at OUT_WIDTH.
- Overflow: an accepted pixel arriving while the FIFO is full (full evaluated before the same-cycle read) is discarded. Then: overflow←1, droppedFrames+=1 (saturating at 255), state→DROP.
- DROP: discard all pixels. On vsync rising edge go to WAIT_FRAME. FIFO contents already written keep draining.
- vsync rising in STREAM (complete or short frame) → WAIT_FRAME. This is not an error.
- Pixels outside the window, and srcY ≥ SRC_HEIGHT, are ignored. Counters saturate at the maximum srcY.
- Counter widths: $clog2 of the respective maximum +1. Comparisons are done in signed-safe widths.

## Timing
- Reset values: state WAIT_FRAME, FIFO empty, pixelValid 0, pixelOut 0, tags 0, overflow 0, droppedFrames 0, fifoLevel 0.
- FIFO is show-ahead. An accepted pixel written at edge N appears on pixelOut with pixelValid=1 after edge N+1 (latency 1 cycle when empty).
- Transfer occurs on the edge where pixelValid&&pixelReady. The next head is presented the following cycle. Full throughput is one pixel per clock.
- pixelOut, tags and pixelValid are stable while pixelValid=1 and pixelReady=0.
- Simultaneous read and write when not full: fifoLevel is unchanged.
- Reset mid-operation flushes the FIFO immediately. The first frame after reset begins only after a vsync fall.

## Structure
- Package ov7670_stream_pkg holds:
  - typedef enum streamState_t {WAIT_FRAME, STREAM, DROP}
  - typedef struct tagged pixel {sof, eol, data}, parametrised via PIXEL_WIDTH localparam in the instantiating module
- Sub-module sync_fifo (width PIXEL_WIDTH+2, depth FIFO_DEPTH):
  - show-ahead, full/empty/level outputs
  - pointer wrap by extra MSB

## Test plan
Bench parameters: SRC 8×4, OUT 4×2, X_OFFSET 2, Y_OFFSET 1, DECIMATE 0, FIFO_DEPTH 4, pixelData = srcY·16+srcX.
- Full frame, pixelReady=1 → outputs 0x12,0x13,0x14,0x15,0x22…0x25. startOfFrame on 0x12 only; endOfLine on 0x15 and 0x25; no overflow.
- DECIMATE=1, OUT 2×1, offsets 0,0 → outputs 0x00, 0x02. endOfLine on 0x02.
- pixelReady=0 throughout frame → 4 pixels buffered, 5th accepted pixel sets overflow and droppedFrames=1. Next frame: overflow clears at vsync fall and startOfFrame reappears.
- pixelReady toggling 1/0 every cycle → every head held stable while stalled; no pixel lost or duplicated.
- Pixels arriving before the first vsync fall → no output. Reset asserted mid-frame → pixelValid=0 and fifoLevel=0 the next cycle.
- 256 consecutive overflowed frames → droppedFrames saturates at 255.
